led_shift_ctrl: RTL

LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

---
 rtl/led_shift_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: one-hot LED chaser with selectable pattern mode.
//   A 16-bit prescaler divides clk by DIV. Each prescaler wrap (the tick) moves
//   the lit LED one position according to the current mode.
//   Optional feature macro: LED_SHIFT_BOUNCE_EN adds BOUNCE mode and the
//   direction flag. Without it the modes alternate LEFT <-> RIGHT.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   mode_req - single-cycle pulse, advances the pattern mode
//   pause    - level, freezes prescaler, LED and direction while high
//   LED      - registered one-hot LED pattern
//   mode     - registered mode (00 LEFT, 01 RIGHT, 10 BOUNCE)
//   step     - registered strobe, high in the cycle the new LED value is shown
module led_shift_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_req,
  input  logic       pause,
  output logic [7:0] LED,
  output logic [1:0] mode,
  output logic       step
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    LEFT   = 2'b00,
    RIGHT  = 2'b01,
    BOUNCE = 2'b10,
    BAD    = 2'b11
  } mode_e;

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       led_q, led_d;
  logic             step_q, step_d;
  logic             mode_chg;
  logic             tick;
`ifdef LED_SHIFT_BOUNCE_EN
  logic             dir_q, dir_d;   // 0 = moving left (toward bit 7), 1 = right
`endif

  assign tick = !pause && (cnt_q == CNT_MAX);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LEFT;
      cnt_q   <= '0;
      led_q   <= 8'h01;
      step_q  <= 1'b0;
`ifdef LED_SHIFT_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      step_q  <= step_d;
`ifdef LED_SHIFT_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Next-state: mode sequencing, prescaler and LED movement
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    step_d   = 1'b0;
    mode_chg = 1'b0;
`ifdef LED_SHIFT_BOUNCE_EN
    dir_d    = dir_q;
`endif

    // Mode sequencing; unused codes fall to default and recover to LEFT
    case (state_q)
      LEFT: begin
        if (mode_req) begin
          state_d  = RIGHT;
          mode_chg = 1'b1;
        end
      end
      RIGHT: begin
        if (mode_req) begin
`ifdef LED_SHIFT_BOUNCE_EN
          state_d  = BOUNCE;
`else
          state_d  = LEFT;
`endif
          mode_chg = 1'b1;
        end
      end
`ifdef LED_SHIFT_BOUNCE_EN
      BOUNCE: begin
        if (mode_req) begin
          state_d  = LEFT;
          mode_chg = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = LEFT;
        mode_chg = 1'b1;
      end
    endcase

    // A mode change overrides both pause and a coincident tick
    if (mode_chg) begin
      led_d  = 8'h01;
      cnt_d  = '0;
      step_d = 1'b0;
`ifdef LED_SHIFT_BOUNCE_EN
      dir_d  = 1'b0;
`endif
    end else if (!pause) begin
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (state_q)
          LEFT:  led_d = {led_q[6:0], led_q[7]};
          RIGHT: led_d = {led_q[0], led_q[7:1]};
`ifdef LED_SHIFT_BOUNCE_EN
          BOUNCE: begin
            // At an end stop, reverse and move away on the same tick
            if (!dir_q) begin
              if (led_q == 8'h80) begin
                dir_d = 1'b1;
                led_d = {1'b0, led_q[7:1]};
              end else begin
                led_d = {led_q[6:0], 1'b0};
              end
            end else begin
              if (led_q == 8'h01) begin
                dir_d = 1'b0;
                led_d = {led_q[6:0], 1'b0};
              end else begin
                led_d = {1'b0, led_q[7:1]};
              end
            end
          end
`endif
          default: led_d = led_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign LED  = led_q;
  assign mode = state_q;
  assign step = step_q;

endmodule
